multdiv_issue_ctrl: RTL and testbench

//   Execute-stage sequencer for the multdiv unit. Accepts a MULT/DIV op from the

---
 rtl/multdiv_pkg.sv | 25 ++
 rtl/md_timeout_counter.sv | 29 ++
 rtl/multdiv_issue_ctrl.sv | 114 +++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types for the multdiv issue sequencer: FSM encoding, op select and
// the operand-B range check applied at accept.
package multdiv_pkg;

    localparam int REG_W_DEFAULT   = 5;
    localparam int TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // multdiv only takes a 16-bit operand B; the upper bits must be pure sign extension
    function automatic logic fits_s16(input logic [31:0] v);
        return (v[31:15] == '0) || (v[31:15] == '1);
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Counts cycles while enabled; terminal is high once TIMEOUT_CYCLES-1 is reached.
// Single-cycle update, no backpressure; clear has priority over enable.
module md_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage sequencer: accept MULT/DIV, launch multdiv, write back result; latency 3 + multdiv.
// Backpressure: stall held through ISSUE/WAIT, md_inputRDY gates the launch, WAIT bounded by timeout.
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int REG_W          = REG_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_mult,
    input  logic             ex_is_div,
    input  logic [31:0]      ex_operandA,
    input  logic [31:0]      ex_operandB,
    input  logic [REG_W-1:0] ex_rd,
    output logic             stall,
    output logic [31:0]      md_operandA,
    output logic [15:0]      md_operandB,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    input  logic [31:0]      md_result,
    input  logic             md_exception,
    input  logic             md_inputRDY,
    input  logic             md_resultRDY,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic [31:0]      wb_data,
    output logic             wb_exception
);

    state_t           state, state_nxt;
    op_t              op_q;
    logic [REG_W-1:0] rd_q;
    logic [31:0]      res_q;
    logic             exc_q;
    logic             accept, legal, timeout;

    md_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (state == ISSUE),
        .enable   (state == WAIT),
        .terminal (timeout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, WB: begin
                if (accept) begin
                    state_nxt = legal ? ISSUE : WB;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE:   if (md_inputRDY) state_nxt = WAIT;
            WAIT:    if (md_resultRDY || timeout) state_nxt = WB;
            default: state_nxt = IDLE;
        endcase
    end

    // WB state doubles as the accept window so back-to-back ops need no bubble
    always_comb begin
        accept       = ex_valid && (ex_is_mult || ex_is_div) && (state == IDLE || state == WB);
        legal        = !(ex_is_mult && ex_is_div) && fits_s16(ex_operandB);
        stall        = accept || (state == ISSUE) || (state == WAIT);
        wb_valid     = (state == WB);
        wb_rd        = wb_valid ? rd_q : '0;
        wb_exception = wb_valid && exc_q;
        wb_data      = (wb_valid && !exc_q) ? res_q : '0;
    end

    // Start pulse is registered, so it lands in the first WAIT cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            md_operandA  <= '0;
            md_operandB  <= '0;
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            op_q         <= OP_MULT;
            rd_q         <= '0;
            res_q        <= '0;
            exc_q        <= 1'b0;
        end else begin
            md_ctrl_MULT <= (state == ISSUE) && md_inputRDY && (op_q == OP_MULT);
            md_ctrl_DIV  <= (state == ISSUE) && md_inputRDY && (op_q == OP_DIV);
            if (accept) begin
                md_operandA <= ex_operandA;
                md_operandB <= ex_operandB[15:0];
                rd_q        <= ex_rd;
                op_q        <= ex_is_div ? OP_DIV : OP_MULT;
                res_q       <= '0;
                exc_q       <= !legal;
            end else if (state == WAIT) begin
                if (md_resultRDY) begin
                    res_q <= md_result;
                    exc_q <= md_exception;
                end else if (timeout) begin
                    exc_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench: default-timeout instance for the main flows, TIMEOUT_CYCLES=8 instance for timeout cases.
module tb_multdiv_issue_ctrl;

    logic        clock, reset;
    logic        ex_valid, ex_is_mult, ex_is_div;
    logic [31:0] ex_operandA, ex_operandB;
    logic [4:0]  ex_rd;
    logic [31:0] md_result;
    logic        md_exception, md_inputRDY, md_resultRDY;

    logic        stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid, wb_exception;
    logic [31:0] md_operandA, wb_data;
    logic [15:0] md_operandB;
    logic [4:0]  wb_rd;

    logic        t8_stall, t8_md_ctrl_MULT, t8_md_ctrl_DIV, t8_wb_valid, t8_wb_exception;
    logic [31:0] t8_md_operandA, t8_wb_data;
    logic [15:0] t8_md_operandB;
    logic [4:0]  t8_wb_rd;

    int n_cmp = 0;
    int n_err = 0;

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(40), .REG_W(5)) dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_mult(ex_is_mult),
        .ex_is_div(ex_is_div), .ex_operandA(ex_operandA), .ex_operandB(ex_operandB),
        .ex_rd(ex_rd), .stall(stall), .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV), .md_result(md_result),
        .md_exception(md_exception), .md_inputRDY(md_inputRDY), .md_resultRDY(md_resultRDY),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exception(wb_exception)
    );

    multdiv_issue_ctrl #(.TIMEOUT_CYCLES(8), .REG_W(5)) dut_t8 (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_mult(ex_is_mult),
        .ex_is_div(ex_is_div), .ex_operandA(ex_operandA), .ex_operandB(ex_operandB),
        .ex_rd(ex_rd), .stall(t8_stall), .md_operandA(t8_md_operandA),
        .md_operandB(t8_md_operandB), .md_ctrl_MULT(t8_md_ctrl_MULT),
        .md_ctrl_DIV(t8_md_ctrl_DIV), .md_result(md_result), .md_exception(md_exception),
        .md_inputRDY(md_inputRDY), .md_resultRDY(md_resultRDY), .wb_valid(t8_wb_valid),
        .wb_rd(t8_wb_rd), .wb_data(t8_wb_data), .wb_exception(t8_wb_exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid     = 1'b0;
        ex_is_mult   = 1'b0;
        ex_is_div    = 1'b0;
        md_resultRDY = 1'b0;
        md_exception = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        md_inputRDY = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        ex_valid    = 1'b1;
        ex_is_mult  = m;
        ex_is_div   = d;
        ex_operandA = a;
        ex_operandB = b;
        ex_rd       = rd;
    endtask

    initial begin
        int pulses, wbs, stalls, n;
        reset       = 1'b1;
        ex_operandA = '0;
        ex_operandB = '0;
        ex_rd       = '0;
        md_result   = '0;
        idle_inputs();
        md_inputRDY = 1'b1;

        // Reset state
        do_reset();
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
        chk("rst_opA", md_operandA, 0);
        chk("rst_wb_data", wb_data, 0);

        // MULT 7 * -3 -> rd 5, multdiv answers 16 cycles after the pulse
        cyc();
        issue(1, 0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        #1; chk("mul_accept_stall", stall, 1);
        cyc(); idle_inputs(); #1;
        chk("mul_opA", md_operandA, 32'd7);
        chk("mul_opB", md_operandB, 16'hFFFD);
        chk("mul_issue_stall", stall, 1);
        cyc(); #1;
        chk("mul_pulse", md_ctrl_MULT, 1);
        chk("mul_no_div", md_ctrl_DIV, 0);
        pulses = 1; wbs = 0;
        for (int i = 3; i <= 17; i++) begin
            cyc(); #1;
            pulses += int'(md_ctrl_MULT);
            wbs    += int'(wb_valid);
        end
        cyc();
        md_resultRDY = 1'b1; md_result = 32'hFFFF_FFEB;
        #1; wbs += int'(wb_valid);
        chk("mul_wait_stall", stall, 1);
        cyc(); idle_inputs(); #1;
        chk("mul_pulse_count", pulses, 1);
        chk("mul_no_early_wb", wbs, 0);
        chk("mul_wb_valid", wb_valid, 1);
        chk("mul_wb_rd", wb_rd, 5);
        chk("mul_wb_data", wb_data, 32'hFFFF_FFEB);
        chk("mul_wb_exc", wb_exception, 0);
        chk("mul_wb_stall", stall, 0);
        cyc(); #1;
        chk("mul_wb_one_cycle", wb_valid, 0);

        // DIV where multdiv flags an exception
        do_reset();
        issue(0, 1, 32'd100, 32'd7, 5'd9);
        #1; cyc(); idle_inputs(); #1; cyc(); #1;
        chk("div_pulse", md_ctrl_DIV, 1);
        chk("div_no_mult", md_ctrl_MULT, 0);
        cyc(); cyc();
        md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'hDEAD_BEEF;
        #1; cyc(); idle_inputs(); #1;
        chk("div_wb_valid", wb_valid, 1);
        chk("div_wb_exc", wb_exception, 1);
        chk("div_wb_data", wb_data, 0);
        chk("div_wb_rd", wb_rd, 9);

        // Operand B out of signed-16 range: exception without starting multdiv
        do_reset();
        issue(1, 0, 32'd5, 32'h0001_0000, 5'd3);
        #1; cyc(); idle_inputs(); #1;
        chk("rng_wb_valid", wb_valid, 1);
        chk("rng_wb_exc", wb_exception, 1);
        chk("rng_wb_data", wb_data, 0);
        chk("rng_wb_rd", wb_rd, 3);
        chk("rng_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
        cyc();
        issue(1, 1, 32'd1, 32'd1, 5'd4);
        #1; cyc(); idle_inputs(); #1;
        chk("both_wb_exc", wb_exception, 1);
        chk("both_wb_rd", wb_rd, 4);
        cyc(); #1;
        chk("both_no_start", {md_ctrl_MULT, md_ctrl_DIV, stall}, 0);

        // multdiv not ready for the first 4 cycles counted from accept
        do_reset();
        md_inputRDY = 1'b0;
        issue(1, 0, 32'd3, 32'd4, 5'd6);
        stalls = 0; pulses = 0;
        for (int i = 0; i <= 3; i++) begin
            #1;
            stalls += int'(stall);
            pulses += int'(md_ctrl_MULT | md_ctrl_DIV);
            cyc();
            idle_inputs();
        end
        md_inputRDY = 1'b1;
        #1; stalls += int'(stall); pulses += int'(md_ctrl_MULT | md_ctrl_DIV);
        cyc(); #1;
        chk("rdy_stall_hold", stalls, 5);
        chk("rdy_no_early_pulse", pulses, 0);
        chk("rdy_pulse", md_ctrl_MULT, 1);
        chk("rdy_stall", stall, 1);

        // Timeout with TIMEOUT_CYCLES=8: exception 8 WAIT cycles after the pulse
        do_reset();
        issue(1, 0, 32'd21, 32'd2, 5'd10);
        #1; cyc(); idle_inputs(); #1; cyc(); #1;
        chk("to_pulse", t8_md_ctrl_MULT, 1);
        chk("to_no_div", t8_md_ctrl_DIV, 0);
        chk("to_opA", t8_md_operandA, 21);
        chk("to_opB", t8_md_operandB, 2);
        n = 0;
        while (t8_wb_valid !== 1'b1 && n < 20) begin
            cyc(); #1; n++;
        end
        chk("to_latency", n, 8);
        chk("to_wb_exc", t8_wb_exception, 1);
        chk("to_wb_data", t8_wb_data, 0);
        chk("to_wb_rd", t8_wb_rd, 10);
        chk("to_wb_stall", t8_stall, 0);
        chk("to_long_still_wait", {wb_valid, stall}, 2'b01);

        // Result and timeout in the same cycle: the result wins
        do_reset();
        issue(1, 0, 32'd2, 32'd3, 5'd11);
        #1; cyc(); idle_inputs(); #1; cyc();
        repeat (7) cyc();
        md_resultRDY = 1'b1; md_result = 32'h0000_1234;
        #1; cyc(); idle_inputs(); #1;
        chk("race_wb_valid", t8_wb_valid, 1);
        chk("race_wb_exc", t8_wb_exception, 0);
        chk("race_wb_data", t8_wb_data, 32'h0000_1234);

        // Reset in WAIT, multdiv answers late
        do_reset();
        issue(1, 0, 32'd8, 32'd8, 5'd12);
        #1; cyc(); idle_inputs(); #1; cyc(); #1; cyc();
        reset = 1'b1;
        #1; cyc();
        reset = 1'b0;
        #1; chk("rw_stall_idle", stall, 0);
        cyc();
        md_resultRDY = 1'b1; md_result = 32'd99;
        wbs = 0; pulses = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            wbs    += int'(wb_valid);
            pulses += int'(md_ctrl_MULT | md_ctrl_DIV);
            cyc();
            idle_inputs();
        end
        #1;
        chk("rw_no_wb", wbs, 0);
        chk("rw_no_pulse", pulses, 0);
        chk("rw_stall", stall, 0);

        // Back-to-back: new op accepted in the WB cycle
        do_reset();
        issue(1, 0, 32'd6, 32'd7, 5'd1);
        #1; cyc(); idle_inputs(); #1; cyc(); #1; cyc();
        md_resultRDY = 1'b1; md_result = 32'd111;
        #1; cyc(); idle_inputs();
        issue(0, 1, 32'd50, 32'd5, 5'd2);
        #1;
        chk("b2b_wb1_valid", wb_valid, 1);
        chk("b2b_wb1_rd", wb_rd, 1);
        chk("b2b_wb1_data", wb_data, 111);
        chk("b2b_wb1_stall", stall, 1);
        cyc(); idle_inputs(); #1;
        chk("b2b_issue", {wb_valid, stall}, 2'b01);
        chk("b2b_opA", md_operandA, 50);
        cyc(); #1;
        chk("b2b_div_pulse", md_ctrl_DIV, 1);
        cyc();
        md_resultRDY = 1'b1; md_result = 32'd10;
        #1; cyc(); idle_inputs();
        issue(1, 0, 32'd1, 32'h8000_0000, 5'd7);
        #1;
        chk("b2b_wb2_rd", wb_rd, 2);
        chk("b2b_wb2_data", wb_data, 10);
        cyc(); idle_inputs(); #1;
        chk("b2b_wb3_valid", wb_valid, 1);
        chk("b2b_wb3_exc", wb_exception, 1);
        chk("b2b_wb3_rd", wb_rd, 7);
        chk("b2b_wb3_stall", stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
